// File: rtl/i2c_poll_scheduler.sv
// Round-robin poll scheduler that shares one i2c_master between sensor channels.
// Optional abort-on-timeout behaviour is enabled with the I2C_TIMEOUT_EN macro.
module i2c_poll_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 4095,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [6:0]      cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic            cfg_en,
    output logic            m_start,
    output logic [6:0]      m_slave_addr,
    output logic [7:0]      m_data,
    input  logic            m_done,
    input  logic [7:0]      m_filtered,
    output logic            res_valid,
    output logic [CH_W-1:0] res_ch,
    output logic [7:0]      res_data,
    output logic            busy,
    output logic            err
);

    localparam int CNT_W = $clog2(PERIOD);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  period_q;
    logic              tick;
    logic [6:0]        tbl_addr [NUM_CH];
    logic [7:0]        tbl_data [NUM_CH];
    logic [NUM_CH-1:0] tbl_en;
    logic              any_en;
    logic [CH_W-1:0]   first_ch, next_ch;
    logic              next_found;
    logic              wait_expired;
    logic [6:0]        addr_q;
    logic [7:0]        data_q;
    logic [CH_W-1:0]   res_ch_q;
    logic [7:0]        res_data_q;

    assign tick = (period_q == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
            tbl_en <= '0;
        end else if (cfg_we) begin
            tbl_addr[cfg_ch] <= cfg_addr;
            tbl_data[cfg_ch] <= cfg_data;
            tbl_en[cfg_ch]   <= cfg_en;
        end
    end

    assign any_en = |tbl_en;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tbl_en[i]) begin
                first_ch = CH_W'(i);
            end
            if (tbl_en[i] && (i > int'(ch_q))) begin
                next_ch    = CH_W'(i);
                next_found = 1'b1;
            end
        end
    end

`ifdef I2C_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q;
    logic              err_q;
    logic              timeout_hit;

    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT));
    assign timeout_hit  = wait_expired &&
                          (((state_q == WAIT_LO) && m_done) ||
                           ((state_q == WAIT_HI) && !m_done));
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wait_q <= '0;
            end else if (((state_q == WAIT_LO) || (state_q == WAIT_HI)) && !wait_expired) begin
                wait_q <= wait_q + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (cfg_we) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign wait_expired   = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // An abort on timeout moves on exactly like CAPTURE, just without the result pulse.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        m_start      = 1'b0;
        res_valid    = 1'b0;
        m_slave_addr = addr_q;
        m_data       = data_q;
        case (state_q)
            IDLE: begin
                if (tick && any_en) begin
                    ch_d    = first_ch;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_start      = 1'b1;
                m_slave_addr = tbl_addr[ch_q];
                m_data       = tbl_data[ch_q];
                state_d      = WAIT_LO;
            end
            WAIT_LO, WAIT_HI: begin
                if ((state_q == WAIT_LO) && !m_done) begin
                    state_d = WAIT_HI;
                end else if ((state_q == WAIT_HI) && m_done) begin
                    state_d = CAPTURE;
                end else if (wait_expired) begin
                    ch_d    = next_found ? next_ch : ch_q;
                    state_d = next_found ? ISSUE : IDLE;
                end
            end
            CAPTURE: begin
                res_valid = 1'b1;
                ch_d      = next_found ? next_ch : ch_q;
                state_d   = next_found ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            data_q     <= '0;
            res_ch_q   <= '0;
            res_data_q <= '0;
        end else begin
            if (state_q == ISSUE) begin
                addr_q <= tbl_addr[ch_q];
                data_q <= tbl_data[ch_q];
            end
            if ((state_q == WAIT_HI) && m_done) begin
                res_ch_q   <= ch_q;
                res_data_q <= m_filtered;
            end
        end
    end

    assign res_ch   = res_ch_q;
    assign res_data = res_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Bench for i2c_poll_scheduler: a behavioural i2c_master plus a round/event scoreboard.
// Define I2C_TIMEOUT_EN for both files to also exercise the abort path.
module tb_i2c_poll_scheduler;

    localparam int NUM_CH  = 4;
    localparam int PERIOD  = 160;
    localparam int TIMEOUT = 50;
    localparam int CH_W    = 2;

    logic            clk = 1'b0;
    logic            rst, cfg_we, cfg_en, m_start, m_done, res_valid, busy, err;
    logic [CH_W-1:0] cfg_ch, res_ch;
    logic [6:0]      cfg_addr, m_slave_addr;
    logic [7:0]      cfg_data, m_data, m_filtered, res_data;

    i2c_poll_scheduler #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_en(cfg_en), .m_start(m_start), .m_slave_addr(m_slave_addr),
        .m_data(m_data), .m_done(m_done), .m_filtered(m_filtered), .res_valid(res_valid),
        .res_ch(res_ch), .res_data(res_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the scheduler's period phase modulo PERIOD.
    int n = 0;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    int checks = 0;
    int errors = 0;

    logic [6:0] mdl_addr [NUM_CH];
    logic [7:0] mdl_data [NUM_CH];
    bit         mdl_en   [NUM_CH];
    int         round_q[$];
    bit         round_active, expect_start, expect_res, to_pending, nodrop;
    int         next_start_n, cur_ch, exp_res_n, exp_res_ch, to_lo, to_hi;
    logic [6:0] cur_addr;
    logic [7:0] exp_res_data;
    bit         mm_active;
    int         mm_phase, mm_lo, mm_len, len_min, len_max, force_filt, start_count;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h n=%0d", tag, got, exp, n);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_CH; i++) begin
            mdl_addr[i] = '0;
            mdl_data[i] = '0;
            mdl_en[i]   = 1'b0;
        end
        round_q.delete();
        round_active = 0; expect_start = 0; expect_res = 0; to_pending = 0; mm_active = 0;
    endtask

    task automatic monitorStep();
        checkOutput("busy", busy, round_active);
        if ((n % PERIOD == PERIOD - 1) && !round_active) begin
            for (int i = 0; i < NUM_CH; i++) if (mdl_en[i]) round_q.push_back(i);
            if (round_q.size() != 0) begin
                round_active = 1; expect_start = 1; next_start_n = n + 1;
            end
        end
        if (m_start) begin
            start_count++;
            if (((expect_start && n == next_start_n) ||
                 (to_pending && n >= to_lo && n <= to_hi)) && round_q.size() != 0) begin
                if (to_pending) checkOutput("err_after_timeout", err, 1);
                expect_start = 0; to_pending = 0;
                cur_ch   = round_q.pop_front();
                cur_addr = mdl_addr[cur_ch];
                checkOutput("start_addr", m_slave_addr, mdl_addr[cur_ch]);
                checkOutput("start_data", m_data, mdl_data[cur_ch]);
                if (nodrop && cur_ch == 0) begin
                    checkOutput("err_before_timeout", err, 0);
                    to_pending = 1; to_lo = n + TIMEOUT; to_hi = n + TIMEOUT + 3;
                end
            end else begin
                checkOutput("spurious_start", m_start, 0);
            end
        end else begin
            if (expect_start && n == next_start_n) checkOutput("start_missing", m_start, 1);
            if (to_pending && n > to_hi) begin
                checkOutput("timeout_restart_missing", m_start, 1);
                to_pending = 0;
            end
        end
        if (expect_res && n == exp_res_n) begin
            checkOutput("res_valid", res_valid, 1);
            checkOutput("res_ch", res_ch, exp_res_ch);
            checkOutput("res_data", res_data, exp_res_data);
            checkOutput("addr_held", m_slave_addr, cur_addr);
            expect_res = 0;
            if (round_q.size() == 0) begin
                round_active = 0;
            end else begin
                expect_start = 1; next_start_n = n + 1;
            end
        end else if (res_valid) begin
            checkOutput("spurious_res", res_valid, 0);
        end
    endtask

    // Behavioural i2c_master: done drops 0..2 cycles after start, stays low, then rises with data.
    task automatic masterStep();
        if (m_start && !(nodrop && cur_ch == 0)) begin
            mm_active = 1; mm_phase = 0;
            mm_lo  = $urandom_range(0, 2);
            mm_len = $urandom_range(len_min, len_max);
        end
        if (mm_active && mm_phase == 0) begin
            if (mm_lo == 0) begin
                m_done = 1'b0; mm_phase = 1;
            end else begin
                mm_lo--;
            end
        end else if (mm_active && mm_phase == 1) begin
            if (mm_len == 0) begin
                m_done     = 1'b1;
                m_filtered = (force_filt >= 0) ? 8'(force_filt) : 8'($urandom);
                mm_active  = 0;
                expect_res = 1; exp_res_n = n + 1; exp_res_ch = cur_ch; exp_res_data = m_filtered;
            end else begin
                mm_len--;
            end
        end
    endtask

    task automatic doCycle();
        @(negedge clk);
        monitorStep();
        masterStep();
        cfg_we = 1'b0;
    endtask

    task automatic applyStimulus(input int ch, input logic [6:0] addr, input logic [7:0] data,
                                 input bit en);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_addr = addr; cfg_data = data; cfg_en = en;
        mdl_addr[ch] = addr; mdl_data[ch] = data; mdl_en[ch] = en;
        doCycle();
    endtask

    task automatic runCycles(input int k, input bit rewrite);
        for (int i = 0; i < k; i++) begin
            if (rewrite && $urandom_range(0, 19) == 0) begin
                int c;
                c = $urandom_range(0, NUM_CH - 1);
                applyStimulus(c, 7'($urandom), 8'($urandom), mdl_en[c]);
            end else begin
                doCycle();
            end
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 4 * PERIOD && round_active; i++) doCycle();
        if (round_active) checkOutput("idle_wait_expired", busy, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_m_start"}, m_start, 0);
        checkOutput({tag, "_addr"}, m_slave_addr, 0);
        checkOutput({tag, "_data"}, m_data, 0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_res_ch"}, res_ch, 0);
        checkOutput({tag, "_res_data"}, res_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0; cfg_en = 1'b0;
        m_done = 1'b1; m_filtered = '0;
        nodrop = 0; len_min = 1; len_max = 25; force_filt = -1; start_count = 0; cur_ch = 0;
        clearModel();
        repeat (3) doCycle();
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] single channel ch0");
        len_min = 20; len_max = 20; force_filt = 8'h64;
        applyStimulus(0, 7'h50, 8'hAC, 1);
        runCycles(3 * PERIOD, 0);
        checkOutput("single_ch_starts", start_count, 3);

        $display("[TB] channels 0,2,3");
        waitIdle();
        len_min = 1; len_max = 25; force_filt = -1;
        applyStimulus(2, 7'h51, 8'h12, 1);
        applyStimulus(3, 7'h52, 8'h34, 1);
        runCycles(2 * PERIOD, 0);

        $display("[TB] rewrite ch0 address while transfer is in flight");
        for (int i = 0; i < 2 * PERIOD && !(mm_active && mm_phase == 1 && cur_ch == 0); i++)
            doCycle();
        checkOutput("reached_ch0_wait", mm_phase, 1);
        applyStimulus(0, 7'h55, 8'hAC, 1);
        runCycles(2 * PERIOD, 0);

        $display("[TB] nothing enabled");
        waitIdle();
        for (int c = 0; c < NUM_CH; c++) applyStimulus(c, mdl_addr[c], mdl_data[c], 0);
        start_count = 0;
        runCycles(3 * PERIOD, 0);
        checkOutput("idle_no_starts", start_count, 0);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 6; r++) begin
            waitIdle();
            for (int c = 0; c < NUM_CH; c++)
                applyStimulus(c, 7'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            runCycles(PERIOD + $urandom_range(0, PERIOD), 1);
        end

`ifdef I2C_TIMEOUT_EN
        $display("[TB] timeout abort on ch0");
        waitIdle();
        applyStimulus(0, 7'h50, 8'hAC, 1);
        applyStimulus(1, 7'h51, 8'h5A, 1);
        applyStimulus(2, 7'h52, 8'h00, 0);
        applyStimulus(3, 7'h53, 8'h00, 0);
        nodrop = 1;
        runCycles(2 * PERIOD, 0);
        waitIdle();
        nodrop = 0;
        applyStimulus(2, 7'h52, 8'h00, 0);
        checkOutput("err_cleared_by_write", err, 0);
`endif

        $display("[TB] reset during transfer");
        waitIdle();
        for (int c = 0; c < NUM_CH; c++) applyStimulus(c, 7'(8'h40 + c), 8'(c), 1);
        len_min = 12; len_max = 20;
        for (int i = 0; i < 2 * PERIOD && !(mm_active && mm_phase == 1); i++) doCycle();
        checkOutput("reached_wait_before_reset", mm_phase, 1);
        doCycle();
        doCycle();
        rst = 1'b1;
        clearModel();
        doCycle();
        checkAllZero("mid_reset");
        rst = 1'b0;
        runCycles(5, 0);
        m_done = 1'b1; m_filtered = 8'hEE;
        start_count = 0;
        runCycles(2 * PERIOD, 0);
        checkOutput("after_reset_no_starts", start_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
